// File: rtl/shift_register.sv
// rtl/shift_register.sv - parallel-load serial shift register with frame count and done pulse
// A load arms a WIDTH-bit frame; each shift_en moves one bit out and one bit in until count hits zero.
module shift_register #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       load,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       shift_en,
   input  logic                       serial_in,
   output logic                       serial_out,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(WIDTH+1)-1:0] count,
   output logic                       busy,
   output logic                       done
);
   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    count_q, count_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // Load always wins; shifts are ignored once the frame is exhausted.
   always_comb begin
      data_d  = data_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (load) begin
         data_d  = data_in;
         count_d = FRAME_LEN;
      end else if (shift_en && (count_q != '0)) begin
         data_d  = LSB_FIRST ? {serial_in, data_q[WIDTH-1:1]}
                             : {data_q[WIDTH-2:0], serial_in};
         count_d = count_q - CW'(1);
         done_d  = (count_q == CW'(1));
      end
   end

   assign serial_out = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
   assign data_out   = data_q;
   assign count      = count_q;
   assign busy       = (count_q != '0);
   assign done       = done_q;

endmodule
